// File: rtl/ans_dec_sched.sv
// ans_dec_sched: shares one ANS decoder between two framed requesters.
// A channel owns the decoder from its header beat until the last decoded
// symbol of its frame has left. Ownership alternates round-robin at frame
// boundaries. A frame ends on its last output, so the decoder never holds
// symbols from two channels at once.
module ans_dec_sched #(
  parameter int SYM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [SYM_WIDTH-1:0] ch0_in,
  input  logic                 ch0_in_vld,
  output logic                 ch0_in_rdy,
  input  logic [SYM_WIDTH-1:0] ch1_in,
  input  logic                 ch1_in_vld,
  output logic                 ch1_in_rdy,
  output logic [SYM_WIDTH-1:0] dec_in,
  output logic                 dec_in_vld,
  input  logic                 dec_in_rdy,
  input  logic [SYM_WIDTH-1:0] dec_out,
  input  logic                 dec_out_vld,
  output logic                 dec_out_rdy,
  output logic [SYM_WIDTH-1:0] out,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 out_ch,
  output logic                 out_last,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 g_q, g_d;
  logic                 pri_q, pri_d;
  logic [SYM_WIDTH-1:0] len_q, len_d;
  logic [SYM_WIDTH-1:0] sent_q, sent_d;
  logic [SYM_WIDTH-1:0] rcvd_q, rcvd_d;

  logic [SYM_WIDTH-1:0] sel_in;
  logic                 sel_vld;
  logic                 pri_vld;
  logic                 in_room;
  logic                 last_sym;
  logic                 grant_rdy;

  // Mux the granted channel and derive the frame-position flags.
  always_comb begin
    sel_in   = g_q ? ch1_in : ch0_in;
    sel_vld  = g_q ? ch1_in_vld : ch0_in_vld;
    pri_vld  = pri_q ? ch1_in_vld : ch0_in_vld;
    in_room  = (sent_q < len_q);
    last_sym = (rcvd_q == (len_q - SYM_WIDTH'(1)));
  end

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    pri_d       = pri_q;
    len_d       = len_q;
    sent_d      = sent_q;
    rcvd_d      = rcvd_q;
    grant_rdy   = 1'b0;
    dec_in_vld  = 1'b0;
    out_vld     = 1'b0;
    dec_out_rdy = 1'b0;
    out_last    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && (ch0_in_vld || ch1_in_vld)) begin
          g_d     = pri_vld ? pri_q : ~pri_q;
          state_d = S_HDR;
        end
      end

      S_HDR: begin
        grant_rdy = en;
        if (en && sel_vld) begin
          len_d  = sel_in;
          sent_d = '0;
          rcvd_d = '0;
          if (sel_in == '0) begin
            // empty frame: nothing will come back, release immediately
            state_d = S_IDLE;
            pri_d   = ~g_q;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        // beats past the frame length stay pending as the next header
        grant_rdy  = en & dec_in_rdy & in_room;
        dec_in_vld = en & sel_vld & in_room;
        if (grant_rdy && sel_vld) begin
          sent_d = sent_q + SYM_WIDTH'(1);
        end

        // output side is not gated by en; only counted handshakes need en
        out_vld     = dec_out_vld;
        dec_out_rdy = out_rdy;
        out_last    = last_sym;
        if (en && dec_out_vld && out_rdy) begin
          rcvd_d = rcvd_q + SYM_WIDTH'(1);
          if (last_sym) begin
            state_d = S_IDLE;
            pri_d   = ~g_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, grant, priority pointer and frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      g_q     <= 1'b0;
      pri_q   <= 1'b0;
      len_q   <= '0;
      sent_q  <= '0;
      rcvd_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      pri_q   <= pri_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      rcvd_q  <= rcvd_d;
    end
  end

  assign ch0_in_rdy = grant_rdy & ~g_q;
  assign ch1_in_rdy = grant_rdy & g_q;
  assign dec_in     = sel_in;
  assign out        = dec_out;
  assign out_ch     = g_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ans_dec_sched.sv
// Bench for ans_dec_sched: requester queues and an identity decoder model
// drive the DUT; expected output symbols are queued when a frame is issued
// and a negedge monitor pops and compares on each counted output handshake.
module tb_ans_dec_sched;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] ch0_in, ch1_in;
  logic         ch0_in_vld, ch1_in_vld;
  logic         ch0_in_rdy, ch1_in_rdy;
  logic [W-1:0] dec_in;
  logic         dec_in_vld;
  logic         dec_in_rdy;
  logic [W-1:0] dec_out;
  logic         dec_out_vld;
  logic         dec_out_rdy;
  logic [W-1:0] out;
  logic         out_vld;
  logic         out_rdy;
  logic         out_ch;
  logic         out_last;
  logic         busy;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] dq[$];
  logic [9:0]   exp_q[$];

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic         pop0, pop1, dpop, dpush;
  logic [W-1:0] dval;
  logic [9:0]   e_sym;
  logic         out_rdy_fix;
  logic         out_pat;
  int           pat_idx;

  int phase;
  int zl_viol, zl_busy;
  int bp_hs, bp_viol, bp_l0;
  int en_viol;
  int lasts_seen;

  always #5 clk = ~clk;

  ans_dec_sched #(.SYM_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ch0_in     (ch0_in),
    .ch0_in_vld (ch0_in_vld),
    .ch0_in_rdy (ch0_in_rdy),
    .ch1_in     (ch1_in),
    .ch1_in_vld (ch1_in_vld),
    .ch1_in_rdy (ch1_in_rdy),
    .dec_in     (dec_in),
    .dec_in_vld (dec_in_vld),
    .dec_in_rdy (dec_in_rdy),
    .dec_out    (dec_out),
    .dec_out_vld(dec_out_vld),
    .dec_out_rdy(dec_out_rdy),
    .out        (out),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_ch     (out_ch),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic expect_sym(input logic ch, input logic last, input logic [W-1:0] d);
    exp_q.push_back({ch, last, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ch0_rdy"},  {31'd0, ch0_in_rdy},  0);
    check({tag, "_ch1_rdy"},  {31'd0, ch1_in_rdy},  0);
    check({tag, "_dec_in_vld"}, {31'd0, dec_in_vld}, 0);
    check({tag, "_dec_out_rdy"}, {31'd0, dec_out_rdy}, 0);
    check({tag, "_out_vld"},  {31'd0, out_vld},     0);
    check({tag, "_out_ch"},   {31'd0, out_ch},      0);
    check({tag, "_out_last"}, {31'd0, out_last},    0);
    check({tag, "_busy"},     {31'd0, busy},        0);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
    end
    cmp_cnt++;
    if (i == bound) begin
      err_cnt++;
      $display("FAIL %s_timeout: %0d symbols still expected after %0d cycles, required 0", name, exp_q.size(), bound);
    end
  endtask

  // Requester and decoder model state update, then refresh of the driven inputs.
  initial begin
    pat_idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        dq.delete();
      end else begin
        if (pop0 && q0.size() != 0) void'(q0.pop_front());
        if (pop1 && q1.size() != 0) void'(q1.pop_front());
        if (dpop && dq.size() != 0) void'(dq.pop_front());
        if (dpush) dq.push_back(dval);
      end
      pat_idx++;
      out_rdy     = out_pat ? ((pat_idx % 3) == 0) : out_rdy_fix;
      ch0_in_vld  = (q0.size() != 0);
      ch0_in      = (q0.size() != 0) ? q0[0] : '0;
      ch1_in_vld  = (q1.size() != 0);
      ch1_in      = (q1.size() != 0) ? q1[0] : '0;
      dec_out_vld = (dq.size() != 0);
      dec_out     = (dq.size() != 0) ? dq[0] : '0;
    end
  end

  // Handshake sampling, scoreboard monitor and per-phase watchers.
  initial begin
    forever begin
      @(negedge clk);
      pop0  = rst_n && ch0_in_vld && ch0_in_rdy;
      pop1  = rst_n && ch1_in_vld && ch1_in_rdy;
      dpush = rst_n && dec_in_vld && dec_in_rdy;
      dval  = dec_in;
      dpop  = rst_n && en && dec_out_vld && dec_out_rdy;

      if (rst_n && en && out_vld && out_rdy) begin
        cmp_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL out_unexpected: got ch=%0d last=%0d data=0x%02h, required no output", out_ch, out_last, out);
        end else begin
          e_sym = exp_q.pop_front();
          if ({out_ch, out_last, out} !== e_sym) begin
            err_cnt++;
            $display("FAIL out_symbol: got ch=%0d last=%0d data=0x%02h, required ch=%0d last=%0d data=0x%02h",
                     out_ch, out_last, out, e_sym[9], e_sym[8], e_sym[7:0]);
          end
        end
        if (out_last) lasts_seen++;
      end

      if (phase == 1) begin
        if (dec_in_vld || out_vld) zl_viol++;
        if (busy) zl_busy++;
      end
      if (phase == 2) begin
        if (bp_hs >= 5 && lasts_seen == bp_l0 && ch0_in_rdy) bp_viol++;
        if (pop0) bp_hs++;
      end
      if (phase == 3 && !en) begin
        if (ch0_in_rdy || ch1_in_rdy || dec_in_vld) en_viol++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d symbols still expected", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    en = 1'b1;
    dec_in_rdy = 1'b1;
    out_rdy_fix = 1'b1;
    out_pat = 1'b0;
    out_rdy = 1'b0;
    ch0_in = '0; ch1_in = '0; ch0_in_vld = 1'b0; ch1_in_vld = 1'b0;
    dec_out = '0; dec_out_vld = 1'b0;
    pop0 = 1'b0; pop1 = 1'b0; dpop = 1'b0; dpush = 1'b0; dval = '0;
    phase = 0; zl_viol = 0; zl_busy = 0; bp_hs = 0; bp_viol = 0; bp_l0 = 0;
    en_viol = 0; lasts_seen = 0;

    // contention from reset: ch0 first, then ch1
    q0 = {8'd2, 8'hA0, 8'hA1};
    q1 = {8'd2, 8'hB0, 8'hB1};
    expect_sym(1'b0, 1'b0, 8'hA0);
    expect_sym(1'b0, 1'b1, 8'hA1);
    expect_sym(1'b1, 1'b0, 8'hB0);
    expect_sym(1'b1, 1'b1, 8'hB1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_idle("after_reset");
    wait_drain("contention1", 100);

    // second contention goes to ch0 again
    idle(2);
    q0 = {8'd1, 8'hA2};
    q1 = {8'd1, 8'hB2};
    expect_sym(1'b0, 1'b1, 8'hA2);
    expect_sym(1'b1, 1'b1, 8'hB2);
    wait_drain("contention2", 100);

    // single frame, busy falls the cycle after the last output
    idle(2);
    q0 = {8'd3, 8'h11, 8'h22, 8'h33};
    expect_sym(1'b0, 1'b0, 8'h11);
    expect_sym(1'b0, 1'b0, 8'h22);
    expect_sym(1'b0, 1'b1, 8'h33);
    wait_drain("single", 100);
    check("single_busy_at_last", {31'd0, busy}, 1);
    @(negedge clk);
    check("single_busy_after", {31'd0, busy}, 0);
    check("single_out_vld_after", {31'd0, out_vld}, 0);

    // zero-length frame on ch1
    idle(2);
    zl_viol = 0; zl_busy = 0;
    phase = 1;
    q1 = {8'd0};
    idle(8);
    phase = 0;
    check("zl_no_traffic", zl_viol, 0);
    check("zl_busy_cycles", zl_busy, 1);
    check("zl_header_taken", q1.size(), 0);

    // priority back on ch0 after the empty ch1 frame
    q0 = {8'd1, 8'hA3};
    q1 = {8'd1, 8'hB3};
    expect_sym(1'b0, 1'b1, 8'hA3);
    expect_sym(1'b1, 1'b1, 8'hB3);
    wait_drain("contention3", 100);

    // backpressure: stalled decoder input, gapped consumer, trailing beat
    idle(2);
    bp_hs = 0; bp_viol = 0; bp_l0 = lasts_seen;
    phase = 2;
    dec_in_rdy = 1'b0;
    out_pat = 1'b1;
    q0 = {8'd4, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'd1, 8'h77};
    expect_sym(1'b0, 1'b0, 8'hC1);
    expect_sym(1'b0, 1'b0, 8'hC2);
    expect_sym(1'b0, 1'b0, 8'hC3);
    expect_sym(1'b0, 1'b1, 8'hC4);
    expect_sym(1'b0, 1'b1, 8'h77);
    idle(5);
    dec_in_rdy = 1'b1;
    wait_drain("backpressure", 300);
    idle(2);
    phase = 0;
    out_pat = 1'b0;
    check("bp_rdy_past_len", bp_viol, 0);
    check("bp_beats_taken", bp_hs, 7);

    // enable gating after the first output
    idle(2);
    en_viol = 0;
    q0 = {8'd3, 8'hD1, 8'hD2, 8'hD3};
    expect_sym(1'b0, 1'b0, 8'hD1);
    expect_sym(1'b0, 1'b0, 8'hD2);
    expect_sym(1'b0, 1'b1, 8'hD3);
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 2) break;
    end
    cmp_cnt++;
    if (k == 100) begin
      err_cnt++;
      $display("FAIL en_first_output_timeout: %0d symbols expected, required 2", exp_q.size());
    end
    @(posedge clk);
    #2;
    en = 1'b0;
    phase = 3;
    idle(5);
    phase = 0;
    en = 1'b1;
    check("en_no_handshake", en_viol, 0);
    check("en_outputs_held", exp_q.size(), 2);
    wait_drain("enable", 100);

    // reset in the middle of a ch0 frame, then a fresh ch1 frame
    idle(2);
    out_rdy_fix = 1'b0;
    q0 = {8'd5, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    for (k = 0; k < 100; k++) begin
      @(posedge clk);
      #2;
      if (q0.size() == 3) break;
    end
    cmp_cnt++;
    if (k == 100) begin
      err_cnt++;
      $display("FAIL rst_partial_timeout: %0d beats pending, required 3", q0.size());
    end
    rst_n = 1'b0;
    q0.delete();
    @(negedge clk);
    check_idle("midrst");
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_midrst");
    out_rdy_fix = 1'b1;
    q1 = {8'd1, 8'h5A};
    expect_sym(1'b1, 1'b1, 8'h5A);
    wait_drain("after_reset_frame", 100);

    idle(3);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
